// File: rtl/bp_lite_to_burst.sv
// rtl/bp_lite_to_burst.sv - BedRock Lite to Burst serializer; optional BP_LITE_TO_BURST_HDR_FIRST_EN holds data until the header is sent.
// Header layout, LSB first: msg_type[3:0], subop[3:0], addr[paddr_width_p], size[2:0], payload[payload_width_p].
module bp_lite_to_burst #(
  parameter int          paddr_width_p    = 40,
  parameter int          in_data_width_p  = 512,
  parameter int          out_data_width_p = 64,
  parameter int          payload_width_p  = 16,
  parameter logic [15:0] payload_mask_p   = '0,
  localparam int out_msg_header_width_lp = 4 + 4 + paddr_width_p + 3 + payload_width_p,
  localparam int in_msg_width_lp         = out_msg_header_width_lp + in_data_width_p
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [in_msg_width_lp-1:0]         in_msg_i,
  input  logic                               in_msg_v_i,
  output logic                               in_msg_ready_and_o,
  output logic [out_msg_header_width_lp-1:0] out_msg_header_o,
  output logic                               out_msg_header_v_o,
  input  logic                               out_msg_header_ready_and_i,
  output logic [out_data_width_p-1:0]        out_msg_data_o,
  output logic                               out_msg_data_v_o,
  input  logic                               out_msg_data_ready_and_i
);

  localparam int unsigned ratio_lp          = in_data_width_p / out_data_width_p;
  localparam int unsigned bytes_per_beat_lp = out_data_width_p / 8;
  localparam int          idx_width_lp      = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  // One extra bit so a fully drained payload is distinguishable from beat 0
  // while the header is still being held off.
  localparam int          cnt_width_lp      = idx_width_lp + 1;
  localparam int          size_lsb_lp       = 8 + paddr_width_p;

  localparam logic [0:0] e_ready = 1'b0;
  localparam logic [0:0] e_busy  = 1'b1;

  logic [0:0]                               state_q, state_d;
  logic                                     header_sent_q, header_sent_d;
  logic [cnt_width_lp-1:0]                  beat_cnt_q, beat_cnt_d;
  logic [cnt_width_lp-1:0]                  num_beats;
  logic [out_msg_header_width_lp-1:0]       header_q;
  logic [ratio_lp-1:0][out_data_width_p-1:0] data_q;

  logic [3:0]  msg_type;
  logic [2:0]  msg_size;
  logic        has_data, busy;
  logic        in_fire, hdr_fire, data_fire, last_beat, done;
  int unsigned size_beats;

  assign msg_type = header_q[3:0];
  assign msg_size = header_q[size_lsb_lp +: 3];
  assign has_data = payload_mask_p[msg_type];
  assign busy     = (state_q == e_busy);

  always_comb begin
    size_beats = (32'd1 << msg_size) / bytes_per_beat_lp;
    if (size_beats == 0)        size_beats = 1;
    if (size_beats > ratio_lp)  size_beats = ratio_lp;
    num_beats = cnt_width_lp'(size_beats);
  end

  assign in_msg_ready_and_o = (state_q == e_ready) & ~reset_i;
  assign in_fire            = in_msg_ready_and_o & in_msg_v_i;

  assign out_msg_header_o   = header_q;
  assign out_msg_header_v_o = busy & ~header_sent_q;

`ifdef BP_LITE_TO_BURST_HDR_FIRST_EN
  assign out_msg_data_v_o = busy & has_data & (beat_cnt_q < num_beats) & header_sent_q;
`else
  assign out_msg_data_v_o = busy & has_data & (beat_cnt_q < num_beats);
`endif
  assign out_msg_data_o   = data_q[beat_cnt_q[idx_width_lp-1:0]];

  assign hdr_fire  = out_msg_header_v_o & out_msg_header_ready_and_i;
  assign data_fire = out_msg_data_v_o & out_msg_data_ready_and_i;
  assign last_beat = data_fire & ((beat_cnt_q + cnt_width_lp'(1)) == num_beats);
  // Beats may drain before the header, so a late header alone can finish the message.
  assign done      = (header_sent_q | hdr_fire)
                   & (~has_data | (beat_cnt_q >= num_beats) | last_beat);

  always_comb begin
    state_d       = state_q;
    header_sent_d = header_sent_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      e_ready: begin
        if (in_fire) begin
          header_sent_d = 1'b0;
          beat_cnt_d    = '0;
          state_d       = e_busy;
        end
      end
      e_busy: begin
        if (hdr_fire)  header_sent_d = 1'b1;
        if (data_fire) beat_cnt_d    = beat_cnt_q + cnt_width_lp'(1);
        if (done)      state_d       = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_ready;
      header_sent_q <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      header_sent_q <= header_sent_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      header_q <= in_msg_i[in_msg_width_lp-1 -: out_msg_header_width_lp];
      data_q   <= in_msg_i[in_data_width_p-1:0];
    end
  end

endmodule
